// File: rtl/dmem_bridge_pkg.sv
// Shared types and constants for the data-side memory bridge: FSM encoding,
// kernel-segment address prefixes and the full-word read strobe.
package dmem_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } bridge_state_e;

    localparam logic [2:0] KSEG0_PREFIX = 3'b100;
    localparam logic [2:0] KSEG1_PREFIX = 3'b101;
    localparam logic [3:0] READ_STRB    = 4'hF;

endpackage

// File: rtl/dmem_addr_map.sv
// Combinational virtual-to-physical translation: kseg0/kseg1 addresses lose
// their top three bits when KSEG_MAP is set, everything else passes through.
module dmem_addr_map
    import dmem_bridge_pkg::*;
#(
    parameter int KSEG_MAP = 1,
    parameter int ADDR_W   = 32
) (
    input  logic [ADDR_W-1:0] vaddr,
    output logic [ADDR_W-1:0] paddr
);

    logic [2:0] segBits;
    logic       isKseg;

    assign segBits = vaddr[ADDR_W-1 -: 3];
    assign isKseg  = (segBits == KSEG0_PREFIX) || (segBits == KSEG1_PREFIX);

    always_comb begin
        paddr = vaddr;
        if ((KSEG_MAP != 0) && isKseg) begin
            paddr[ADDR_W-1 -: 3] = 3'b000;
        end
    end

endmodule

// File: rtl/dmem_bridge.sv
// Bridges the M-stage data access onto a request/response bus, one access at a
// time, and holds the result in DONE until the pipeline is free to advance.
module dmem_bridge
    import dmem_bridge_pkg::*;
#(
    parameter int KSEG_MAP = 1,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    input  logic              longest_stall,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [3:0]        bus_strb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [31:0]       bus_rdata,
    output logic [1:0]        dbgState
);

    // Handshake: the address phase completes in the cycle bus_req and
    // bus_addr_ok are both high; the response is the single-cycle bus_data_ok
    // pulse that follows (possibly in that same cycle).
    bridge_state_e state, stateNext;
    logic [ADDR_W-1:0] physAddr;
    logic addrHandshake;
    logic loadReq;
    logic respValid;
    logic captureRdata;

    dmem_addr_map #(
        .KSEG_MAP(KSEG_MAP),
        .ADDR_W  (ADDR_W)
    ) u_addr_map (
        .vaddr(cpu_addr),
        .paddr(physAddr)
    );

    assign addrHandshake = (state == ADDR) && bus_addr_ok;
    assign respValid     = bus_data_ok && (addrHandshake || (state == DATA));
    assign captureRdata  = respValid && !bus_wr;
    assign loadReq       = (state == IDLE) && cpu_en;

    assign bus_req   = (state == ADDR);
    assign cpu_stall = cpu_en && (state != DONE);
    assign dbgState  = state;

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: if (cpu_en) stateNext = ADDR;
            ADDR: if (bus_addr_ok) stateNext = bus_data_ok ? DONE : DATA;
            DATA: if (bus_data_ok) stateNext = DONE;
            DONE: if (!longest_stall) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Request fields are latched once at issue so a CPU that changes its
    // inputs mid-transaction cannot disturb the bus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_wr    <= 1'b0;
            bus_strb  <= 4'h0;
            bus_addr  <= '0;
            bus_wdata <= 32'h0;
        end else if (loadReq) begin
            bus_wr    <= (cpu_wen != 4'h0);
            bus_strb  <= (cpu_wen != 4'h0) ? cpu_wen : READ_STRB;
            bus_addr  <= physAddr;
            bus_wdata <= cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_rdata <= 32'h0;
        end else if (captureRdata) begin
            cpu_rdata <= bus_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge: scripted bus timing, with request fields and
// load data predicted into queues and compared when the bridge produces them.
module tb_dmem_bridge;
    import dmem_bridge_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [3:0]  strb;
        logic [31:0] addr;
        logic [31:0] vaddr;
        logic [31:0] wdata;
    } bus_rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_en;
    logic [3:0]  cpu_wen;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        longest_stall;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    logic [31:0] cpu_rdata,  cpu_rdata0;
    logic        cpu_stall,  cpu_stall0;
    logic        bus_req,    bus_req0;
    logic        bus_wr,     bus_wr0;
    logic [3:0]  bus_strb,   bus_strb0;
    logic [31:0] bus_addr,   bus_addr0;
    logic [31:0] bus_wdata,  bus_wdata0;
    logic [1:0]  dbgState,   dbgState0;

    logic [31:0] expQ[$];
    bus_rec_t    busExpQ[$];
    logic [31:0] lastRdata;
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    dmem_bridge #(.KSEG_MAP(1), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .longest_stall(longest_stall),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_strb(bus_strb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .dbgState(dbgState)
    );

    // Unmapped twin running in lockstep on the same inputs.
    dmem_bridge #(.KSEG_MAP(0), .ADDR_W(32)) dut0 (
        .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wen(cpu_wen),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata0),
        .cpu_stall(cpu_stall0), .longest_stall(longest_stall),
        .bus_req(bus_req0), .bus_wr(bus_wr0), .bus_strb(bus_strb0),
        .bus_addr(bus_addr0), .bus_wdata(bus_wdata0), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .dbgState(dbgState0)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        tests++;
        assert (obs === want) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    function automatic logic [31:0] mapAddr(input logic [31:0] a);
        if (a[31:29] == 3'b100 || a[31:29] == 3'b101) return {3'b000, a[28:0]};
        return a;
    endfunction

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            cpu_en = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
            longest_stall = 1'b0; bus_rdata = $urandom;
            @(negedge clk);
            check("idle_stall", {31'b0, cpu_stall}, 32'd0);
            check("idle_req", {31'b0, bus_req}, 32'd0);
            check("idle_rdata_hold", cpu_rdata, lastRdata);
        end
    endtask

    // One access: addrWait ADDR cycles before addr_ok, dataWait cycles from the
    // handshake to data_ok (0 = same cycle), then holdStall held DONE cycles.
    task automatic runAccess(input logic [3:0] wen, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int addrWait, input int dataWait,
                             input int holdStall, input bit dropEn);
        bus_rec_t rec;
        bit isRead;
        isRead = (wen == 4'h0);
        @(posedge clk); #1;
        cpu_en = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; longest_stall = 1'b0;
        bus_rdata = $urandom;
        busExpQ.push_back('{wr: !isRead, strb: isRead ? 4'hF : wen,
                            addr: mapAddr(addr), vaddr: addr, wdata: wdata});
        if (isRead) expQ.push_back(rdata);
        @(negedge clk);
        check("issue_stall", {31'b0, cpu_stall}, 32'd1);
        check("issue_no_req", {31'b0, bus_req}, 32'd0);

        for (int i = 0; i < addrWait; i++) begin
            @(posedge clk); #1;
            bus_addr_ok = 1'b0; bus_data_ok = (i == 0); bus_rdata = $urandom;
            @(negedge clk);
            check("addr_wait_req", {31'b0, bus_req}, 32'd1);
            check("addr_wait_stall", {31'b0, cpu_stall}, 32'd1);
        end

        @(posedge clk); #1;
        bus_addr_ok = 1'b1; bus_data_ok = (dataWait == 0);
        bus_rdata = (dataWait == 0) ? rdata : $urandom;
        @(negedge clk);
        rec = busExpQ.pop_front();
        check("hs_req", {31'b0, bus_req}, 32'd1);
        check("hs_wr", {31'b0, bus_wr}, {31'b0, rec.wr});
        check("hs_strb", {28'b0, bus_strb}, {28'b0, rec.strb});
        check("hs_addr", bus_addr, rec.addr);
        check("hs_addr_unmapped", bus_addr0, rec.vaddr);
        check("hs_wdata", bus_wdata, rec.wdata);
        check("hs_stall", {31'b0, cpu_stall}, 32'd1);

        for (int j = 1; j <= dataWait; j++) begin
            @(posedge clk); #1;
            bus_addr_ok = 1'b0; bus_data_ok = (j == dataWait);
            bus_rdata = (j == dataWait) ? rdata : $urandom;
            if (dropEn) cpu_en = 1'b0;
            @(negedge clk);
            check("data_no_req", {31'b0, bus_req}, 32'd0);
            check("data_stall", {31'b0, cpu_stall}, dropEn ? 32'd0 : 32'd1);
        end

        for (int k = 0; k <= holdStall; k++) begin
            @(posedge clk); #1;
            bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = $urandom;
            longest_stall = (k < holdStall);
            if (dropEn) cpu_en = 1'b0;
            @(negedge clk);
            if (k == 0 && isRead) lastRdata = expQ.pop_front();
            check("done_state", {30'b0, dbgState}, {30'b0, DONE});
            check("done_stall", {31'b0, cpu_stall}, 32'd0);
            check("done_no_req", {31'b0, bus_req}, 32'd0);
            check("done_rdata", cpu_rdata, lastRdata);
            check("done_rdata_unmapped", cpu_rdata0, lastRdata);
        end
    endtask

    initial begin
        rst = 1'b0; cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h8000_0000;
        cpu_wdata = 32'h0; longest_stall = 1'b0; bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0; bus_rdata = 32'h0; lastRdata = 32'h0;

        @(negedge clk);
        check("rst_stall_follows_en", {31'b0, cpu_stall}, 32'd1);
        check("rst_state", {30'b0, dbgState}, {30'b0, IDLE});
        check("rst_req", {31'b0, bus_req}, 32'd0);
        check("rst_wr", {31'b0, bus_wr}, 32'd0);
        check("rst_strb", {28'b0, bus_strb}, 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        cpu_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        idleCycles(1);

        // Zero-wait kseg0 read.
        runAccess(4'h0, 32'h8000_0010, 32'h0, 32'h1234_5678, 0, 0, 0, 1'b0);
        // kseg1 partial write, addr_ok in cycle 3, data_ok in cycle 5.
        runAccess(4'b0011, 32'hBFAF_0000, 32'hDEAD_BEEF, 32'h0, 2, 2, 0, 1'b0);
        // Read held in DONE by a 4-cycle global stall; the next issue checks IDLE.
        runAccess(4'h0, 32'h0000_0200, 32'h0, 32'hA5A5_0F0F, 1, 1, 4, 1'b0);
        // Back-to-back reads from consecutive instructions.
        runAccess(4'h0, 32'h8000_0100, 32'h0, 32'h0000_0011, 0, 1, 0, 1'b0);
        runAccess(4'h0, 32'h8000_0104, 32'h0, 32'h0000_0022, 0, 0, 0, 1'b0);
        // Unmapped user address, then kseg0 base seen by both builds.
        runAccess(4'h0, 32'h0000_1000, 32'h0, 32'h5555_AAAA, 0, 0, 0, 1'b0);
        runAccess(4'h0, 32'h8000_0000, 32'h0, 32'h7777_1111, 1, 0, 0, 1'b0);
        // cpu_en dropped mid-transaction still completes.
        runAccess(4'h0, 32'hA000_0040, 32'h0, 32'h0BAD_CAFE, 0, 3, 1, 1'b1);
        idleCycles(2);

        for (int n = 0; n < 8; n++) begin
            logic [3:0] w;
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            runAccess(w, $urandom, $urandom, $urandom,
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), 1'b0);
        end
        idleCycles(1);

        // Reset while waiting for data, then a stray data_ok afterwards.
        @(posedge clk); #1;
        cpu_en = 1'b1; cpu_wen = 4'h0; cpu_addr = 32'h8000_0300;
        @(posedge clk); #1;
        bus_addr_ok = 1'b1; bus_data_ok = 1'b0;
        @(posedge clk); #1;
        bus_addr_ok = 1'b0;
        @(negedge clk);
        check("pre_rst_state", {30'b0, dbgState}, {30'b0, DATA});
        #1;
        rst = 1'b0; cpu_en = 1'b0;
        #1;
        check("mid_rst_state", {30'b0, dbgState}, {30'b0, IDLE});
        check("mid_rst_req", {31'b0, bus_req}, 32'd0);
        check("mid_rst_addr", bus_addr, 32'd0);
        check("mid_rst_rdata", cpu_rdata, 32'd0);
        lastRdata = 32'h0;
        @(posedge clk); #1;
        rst = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        check("stray_rdata", cpu_rdata, 32'd0);
        check("stray_state", {30'b0, dbgState}, {30'b0, IDLE});
        idleCycles(1);
        check("stray_rdata_after", cpu_rdata, 32'd0);

        runAccess(4'h0, 32'h8000_0400, 32'h0, 32'h600D_D00D, 0, 0, 0, 1'b0);
        idleCycles(1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dmem_bridge.md
DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter: KSEG_MAP, default 1, strips kseg0/kseg1 virtual addresses to physical when 1 and passes them through unchanged when 0.
REQ-002 Parameter: ADDR_W, default 32, sets the width of CPU and bus addresses.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cpu_en  in  1  M-stage data access request; held stable by the CPU while stalled.
REQ-006 cpu_wen  in  4  byte write enables; 0 means read, nonzero means write.
REQ-007 cpu_addr  in  ADDR_W  byte address of the access.
REQ-008 cpu_wdata  in  32  store data, already lane-aligned.
REQ-009 cpu_rdata  out  32  registered load data.
REQ-010 cpu_stall  out  1  data-side stall to the hazard unit.
REQ-011 longest_stall  in  1  global pipeline stall; the M stage advances only when it is 0.
REQ-012 bus_req  out  1  bus request valid.
REQ-013 bus_wr  out  1  1 means write.
REQ-014 bus_strb  out  4  byte strobes; equals cpu_wen for writes and 4'hF for reads.
REQ-015 bus_addr  out  ADDR_W  physical address.
REQ-016 bus_wdata  out  32  write data.
REQ-017 bus_addr_ok  in  1  request accepted; the handshake completes when bus_req and bus_addr_ok are both 1.
REQ-018 bus_data_ok  in  1  one-cycle response pulse; carries bus_rdata on reads.
REQ-019 bus_rdata  in  32  read response data.

Function
REQ-020 FSM states and transitions:
- IDLE goes to ADDR when cpu_en is 1.
- ADDR goes to DATA on the address handshake.
- ADDR goes directly to DONE on the address handshake when bus_data_ok is 1 in the same cycle.
- DATA goes to DONE when bus_data_ok is 1.
- DONE goes to IDLE when longest_stall is 0.
REQ-021 cpu_stall = cpu_en & (state != DONE), combinational; it rises in the same cycle a request appears in IDLE.
REQ-022 bus_req is 1 only in ADDR; bus_wr, bus_strb, bus_addr and bus_wdata are registered on IDLE->ADDR and held until the handshake.
REQ-023 cpu_rdata captures bus_rdata on the bus_data_ok cycle of a read and holds it until the next read capture; writes leave it unchanged.
REQ-024 The DONE state holds the result and keeps cpu_stall at 0 while longest_stall is 1 (for example, an i-side stall), so the same held request is never reissued.
REQ-025 Minimum latency: a request in cycle 0 gives bus_req in cycle 1; with addr_ok and data_ok both in cycle 1, cpu_stall is 1 in cycles 0 and 1 and 0 in cycle 2.
REQ-026 Address mapping when KSEG_MAP is 1:
- cpu_addr[31:29] of 3'b100 or 3'b101 maps to bus_addr = {3'b000, cpu_addr[28:0]}.
- All other addresses map to bus_addr = cpu_addr unchanged.
REQ-027 bus_data_ok received in IDLE or ADDR without a handshake is ignored.
REQ-028 cpu_en falling mid-transaction does not abort the transaction; the FSM completes it and then returns to IDLE.
REQ-029 At most one transaction is outstanding at a time; there is no pipelining of requests.

Reset
REQ-030 While rst is 0, the block enters IDLE asynchronously with bus_req 0, bus_wr 0, bus_strb 0, bus_addr 0, bus_wdata 0 and cpu_rdata 0.
REQ-031 cpu_stall during reset equals cpu_en, per REQ-021 with state IDLE.
REQ-032 Reset asserted mid-transaction abandons the transaction; a late bus_data_ok after reset is ignored per REQ-027.

Structure
REQ-033 A shared package holds:
- the FSM state encoding (IDLE, ADDR, DATA, DONE, 2 bits);
- the KSEG0/KSEG1 prefix constants;
- the 4'hF read-strobe constant.
REQ-034 One sub-module, dmem_addr_map, holds the combinational KSEG translation; everything else stays in dmem_bridge.
REQ-035 The implementation targets 150-250 lines of RTL.

Verification
REQ-036 Read with a zero-wait bus: addr 0x8000_0010, addr_ok and data_ok in cycle 1, rdata 0x1234_5678 -> bus_addr 0x0000_0010, 2 stall cycles, cpu_rdata = 0x1234_5678.
REQ-037 Write with latency: wen 4'b0011, addr 0xBFAF_0000, wdata 0xDEAD_BEEF, addr_ok in cycle 3, data_ok in cycle 5 -> bus_wr 1, bus_strb 4'b0011, bus_addr 0x1FAF_0000, cpu_stall 1 through cycle 5 and 0 in cycle 6.
REQ-038 Held global stall: longest_stall 1 for 4 cycles after DONE -> exactly one bus_req handshake, cpu_stall 0 throughout DONE, return to IDLE when longest_stall is 0.
REQ-039 Back-to-back reads of 0x11 then 0x22 from consecutive instructions -> two separate handshakes, and cpu_rdata updates 0x11 then 0x22.
REQ-040 Reset pulled low in DATA -> IDLE with bus_req 0 immediately; a following stray data_ok leaves cpu_rdata at 0.
REQ-041 Unmapped address 0x0000_1000 with KSEG_MAP 1, and 0x8000_0000 with KSEG_MAP 0 -> bus_addr equals cpu_addr in both cases.
